// File: rtl/count_op_sequencer_pkg.sv
// Shared definitions for the countEN/op_done sequencer: state encoding and
// default parameter values.
package count_op_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_GAP  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int DEF_OPS_W      = 32'sd8;
  localparam int DEF_GAP_CYCLES = 32'sd2;
  localparam int DEF_TIMEOUT    = 32'sd64;

endpackage : count_op_sequencer_pkg

// File: rtl/count_op_sequencer_watchdog.sv
// Loadable down-counter shared by the RUN timeout check and the GAP timer;
// expired is high once the count has reached zero.
module op_watchdog #(
  parameter int CNT_W = 32'sd6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: load has priority, otherwise count down and stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule : op_watchdog

// File: rtl/count_op_sequencer.sv
// Initiator-side sequencer for the counter block's countEN/op_done handshake:
// runs a job of num_ops operations with idle gaps and a no-response watchdog.
module count_op_sequencer
  import count_op_sequencer_pkg::*;
#(
  parameter int OPS_W      = DEF_OPS_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [OPS_W-1:0] num_ops,
  input  logic             abort,
  input  logic             op_done,
  output logic             countEN,
  output logic             busy,
  output logic [OPS_W-1:0] ops_completed,
  output logic             job_done,
  output logic             timeout_err
);

  localparam int WD_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int WD_W   = $clog2(WD_MAX);
  // the counter is loaded with N-1 so that expired marks the N-th cycle
  localparam logic [WD_W-1:0]  RUN_LOAD = WD_W'(TIMEOUT - 32'sd1);
  localparam logic [WD_W-1:0]  GAP_LOAD = WD_W'(GAP_CYCLES - 32'sd1);
  localparam logic [OPS_W-1:0] OPS_ONE  = OPS_W'(1'b1);

  state_e           state_q, state_d;
  logic [OPS_W-1:0] num_ops_q, num_ops_d;
  logic [OPS_W-1:0] ops_q, ops_d;
  logic             count_en_q, count_en_d;
  logic             busy_q, busy_d;
  logic             job_done_q, job_done_d;
  logic             timeout_err_q, timeout_err_d;

  logic             accept_start_s;
  logic             op_hit_s;
  logic [OPS_W-1:0] ops_inc_s;
  logic             wd_load_s;
  logic [WD_W-1:0]  wd_load_val_s;
  logic             wd_expired_s;

  assign accept_start_s = (state_q == ST_IDLE) && start && !abort;
  assign op_hit_s       = (state_q == ST_RUN) && op_done && !abort;
  assign ops_inc_s      = ops_q + OPS_ONE;

  op_watchdog #(
    .CNT_W (WD_W)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .load     (wd_load_s),
    .load_val (wd_load_val_s),
    .expired  (wd_expired_s)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; abort outranks every other event
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = (num_ops == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (op_done) begin
          state_d = (ops_inc_s == num_ops_q) ? ST_DONE : ST_GAP;
        end else if (wd_expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wd_expired_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they can be registered
  // without adding a cycle of latency
  always_comb begin
    count_en_d    = (state_d == ST_RUN);
    busy_d        = (state_d != ST_IDLE);
    job_done_d    = (state_d == ST_DONE);
    num_ops_d     = accept_start_s ? num_ops : num_ops_q;
    ops_d         = ops_q;
    timeout_err_d = timeout_err_q;
    wd_load_s     = 1'b0;
    wd_load_val_s = RUN_LOAD;
    if (accept_start_s) begin
      ops_d = '0;
    end else if (op_hit_s) begin
      ops_d = ops_inc_s;
    end else begin
      ops_d = ops_q;
    end
    if (accept_start_s) begin
      timeout_err_d = 1'b0;
    end else if (state_d == ST_ERR) begin
      timeout_err_d = 1'b1;
    end else begin
      timeout_err_d = timeout_err_q;
    end
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      wd_load_s     = 1'b1;
      wd_load_val_s = RUN_LOAD;
    end else if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
      wd_load_s     = 1'b1;
      wd_load_val_s = GAP_LOAD;
    end else begin
      wd_load_s     = 1'b0;
      wd_load_val_s = RUN_LOAD;
    end
  end

  // output and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      num_ops_q     <= '0;
      ops_q         <= '0;
      count_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      job_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      num_ops_q     <= num_ops_d;
      ops_q         <= ops_d;
      count_en_q    <= count_en_d;
      busy_q        <= busy_d;
      job_done_q    <= job_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign countEN       = count_en_q;
  assign busy          = busy_q;
  assign ops_completed = ops_q;
  assign job_done      = job_done_q;
  assign timeout_err   = timeout_err_q;

endmodule : count_op_sequencer

// File: tb/tb_count_op_sequencer.sv
// Scoreboard bench: stimulus pushes expected output events (type, cycle,
// ops_completed); a negedge monitor detects events and compares in order.
module tb_count_op_sequencer;

  localparam int OPS_W = 8;

  localparam int EV_BUSY_RISE = 0;
  localparam int EV_EN_RISE   = 1;
  localparam int EV_EN_FALL   = 2;
  localparam int EV_JOB_DONE  = 3;
  localparam int EV_TERR_SET  = 4;
  localparam int EV_TERR_CLR  = 5;
  localparam int EV_BUSY_FALL = 6;

  typedef struct {
    int ev;
    int cyc;
    int ops;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [OPS_W-1:0] num_ops = '0;
  logic             abort = 1'b0;
  logic             op_done = 1'b0;
  logic             countEN;
  logic             busy;
  logic [OPS_W-1:0] ops_completed;
  logic             job_done;
  logic             timeout_err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic en_p = 1'b0, busy_p = 1'b0, terr_p = 1'b0;
  exp_t exp_q[$];

  count_op_sequencer #(
    .OPS_W(OPS_W), .GAP_CYCLES(2), .TIMEOUT(64)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .num_ops(num_ops),
    .abort(abort), .op_done(op_done), .countEN(countEN), .busy(busy),
    .ops_completed(ops_completed), .job_done(job_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  function automatic string ev_name(input int e);
    case (e)
      EV_BUSY_RISE: return "busy_rise";
      EV_EN_RISE:   return "en_rise";
      EV_EN_FALL:   return "en_fall";
      EV_JOB_DONE:  return "job_done";
      EV_TERR_SET:  return "terr_set";
      EV_TERR_CLR:  return "terr_clr";
      EV_BUSY_FALL: return "busy_fall";
      default:      return "unknown";
    endcase
  endfunction

  task automatic push(input int ev, input int c, input int ops);
    exp_t e;
    e.ev = ev; e.cyc = c; e.ops = ops;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int ev);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got %s@%0d ops=%0d required none",
               ev_name(ev), cyc, ops_completed);
    end else begin
      e = exp_q.pop_front();
      if (e.ev != ev || e.cyc != cyc || e.ops != int'(ops_completed)) begin
        errors++;
        $display("FAIL event got %s@%0d ops=%0d required %s@%0d ops=%0d",
                 ev_name(ev), cyc, ops_completed, ev_name(e.ev), e.cyc, e.ops);
      end
    end
  endtask

  // monitor: edge detection at negedge, fixed in-cycle event order
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !busy_p)               observe(EV_BUSY_RISE);
      if (countEN && !en_p)              observe(EV_EN_RISE);
      if (!countEN && en_p)              observe(EV_EN_FALL);
      if (job_done)                      observe(EV_JOB_DONE);
      if (timeout_err && !terr_p)        observe(EV_TERR_SET);
      if (!timeout_err && terr_p)        observe(EV_TERR_CLR);
      if (!busy && busy_p)               observe(EV_BUSY_FALL);
    end
    en_p   <= countEN;
    busy_p <= busy;
    terr_p <= timeout_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_op_done(input int c);
    goto(c);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
  endtask

  task automatic start_job(input int n, output int s);
    tick();
    s = cyc;
    start = 1'b1;
    num_ops = OPS_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_countEN"}, int'(countEN), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ops"}, int'(ops_completed), 0);
    chk({tag, "_job_done"}, int'(job_done), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  initial begin
    int s;
    repeat (3) tick();
    reset = 1'b0;
    check_idle("reset");
    mon_en = 1'b1;

    // spurious op_done in IDLE
    tick();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;

    // three-op job, op_done 4 cycles after each rise, plus noise
    start_job(3, s);
    push(EV_BUSY_RISE, s + 1, 0);  push(EV_EN_RISE, s + 1, 0);
    push(EV_EN_FALL, s + 6, 1);    push(EV_EN_RISE, s + 8, 1);
    push(EV_EN_FALL, s + 13, 2);   push(EV_EN_RISE, s + 15, 2);
    push(EV_EN_FALL, s + 20, 3);   push(EV_JOB_DONE, s + 20, 3);
    push(EV_BUSY_FALL, s + 21, 3);
    pulse_op_done(s + 5);
    pulse_op_done(s + 7);
    goto(s + 9);
    start = 1'b1; num_ops = 8'd7;
    tick();
    start = 1'b0;
    pulse_op_done(s + 12);
    pulse_op_done(s + 19);
    goto(s + 25);

    // zero-op job
    start_job(0, s);
    push(EV_BUSY_RISE, s + 1, 0);  push(EV_JOB_DONE, s + 1, 0);
    push(EV_BUSY_FALL, s + 2, 0);
    goto(s + 5);

    // op_done withheld: watchdog fires after 64 high cycles
    start_job(2, s);
    push(EV_BUSY_RISE, s + 1, 0);  push(EV_EN_RISE, s + 1, 0);
    push(EV_EN_FALL, s + 65, 0);   push(EV_TERR_SET, s + 65, 0);
    push(EV_BUSY_FALL, s + 66, 0);
    goto(s + 70);

    // next start clears timeout_err; op_done on the terminal cycle wins
    start_job(1, s);
    push(EV_BUSY_RISE, s + 1, 0);  push(EV_EN_RISE, s + 1, 0);
    push(EV_TERR_CLR, s + 1, 0);
    push(EV_EN_FALL, s + 65, 1);   push(EV_JOB_DONE, s + 65, 1);
    push(EV_BUSY_FALL, s + 66, 1);
    pulse_op_done(s + 64);
    goto(s + 70);

    // abort in the GAP after op 1 of 5, then spurious op_done in IDLE
    start_job(5, s);
    push(EV_BUSY_RISE, s + 1, 0);  push(EV_EN_RISE, s + 1, 0);
    push(EV_EN_FALL, s + 6, 1);    push(EV_BUSY_FALL, s + 7, 1);
    pulse_op_done(s + 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    pulse_op_done(s + 9);
    goto(s + 12);

    // abort and start together in IDLE: start dropped
    start = 1'b1; abort = 1'b1; num_ops = 8'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (4) tick();

    // reset asserted while countEN is high on op 2
    start_job(4, s);
    push(EV_BUSY_RISE, s + 1, 0);  push(EV_EN_RISE, s + 1, 0);
    push(EV_EN_FALL, s + 6, 1);    push(EV_EN_RISE, s + 8, 1);
    push(EV_EN_FALL, s + 10, 0);   push(EV_BUSY_FALL, s + 10, 0);
    pulse_op_done(s + 5);
    goto(s + 9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midjob_reset");

    // normal job after reset
    start_job(1, s);
    push(EV_BUSY_RISE, s + 1, 0);  push(EV_EN_RISE, s + 1, 0);
    push(EV_EN_FALL, s + 6, 1);    push(EV_JOB_DONE, s + 6, 1);
    push(EV_BUSY_FALL, s + 7, 1);
    pulse_op_done(s + 5);
    goto(s + 10);

    chk("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_count_op_sequencer
